// File: rtl/calc_pkg.sv
// Shared encodings for the sequential calculator: function codes and FSM states.
package calc_pkg;

  localparam logic [1:0] FCT_ADD = 2'b00;
  localparam logic [1:0] FCT_SUB = 2'b01;
  localparam logic [1:0] FCT_MUL = 2'b10;
  localparam logic [1:0] FCT_DIV = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DIV,
    DONE
  } state_t;

endpackage

// File: rtl/seq_divider.sv
// Bit-serial restoring divider: init loads operands, then one quotient bit per cycle for WIDTH cycles.
// last is high during the final step; quotient/remainder are final from the following cycle.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             init,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             last
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] dsr_r;
  logic [WIDTH:0]   rem_r;
  logic [CW-1:0]    cnt;
  logic             active;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  // Trial subtraction; a borrow out (msb set) means restore the shifted value.
  assign shifted = {rem_r[WIDTH-1:0], quo_r[WIDTH-1]};
  assign trial   = shifted - {1'b0, dsr_r};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_r  <= '0;
      dsr_r  <= '0;
      rem_r  <= '0;
      cnt    <= '0;
      active <= 1'b0;
    end else if (init) begin
      quo_r  <= dividend;
      dsr_r  <= divisor;
      rem_r  <= '0;
      cnt    <= CW'(WIDTH - 1);
      active <= 1'b1;
    end else if (active) begin
      quo_r <= {quo_r[WIDTH-2:0], ~trial[WIDTH]};
      rem_r <= trial[WIDTH] ? shifted : trial;
      if (cnt == '0) active <= 1'b0;
      else           cnt    <= cnt - 1'b1;
    end
  end

  assign quotient  = quo_r;
  assign remainder = rem_r[WIDTH-1:0];
  assign last      = active && (cnt == '0);

endmodule

// File: rtl/seq_calculator.sv
// Multi-cycle add/sub/mul/div unit with registered results and a one-cycle done pulse.
// Define CALC_SIGNED_EN for two's-complement operands (signed mul, truncating div).
module seq_calculator
  import calc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic [1:0]         fct_i,
  output logic               busy_o,
  output logic [2*WIDTH-1:0] res_o,
  output logic [2*WIDTH-1:0] rem_o,
  output logic               done_o,
  output logic               div0_o
);

  localparam int RW = 2 * WIDTH;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q;
  logic [1:0]       fct_q;
  logic [RW-1:0]    alu_q;
  logic             div0_q;
  logic [RW-1:0]    a_x, b_x;
  logic [WIDTH-1:0] dvd_mag, dsr_mag, div_quo, div_rem;
  logic [RW-1:0]    quo_ext, rem_ext, quo_fix, rem_fix;
  logic             div_init, div_last;

  assign div_init = (state == EXEC) && (fct_q == FCT_DIV) && (b_q != '0);
  assign quo_ext  = {{WIDTH{1'b0}}, div_quo};
  assign rem_ext  = {{WIDTH{1'b0}}, div_rem};

`ifdef CALC_SIGNED_EN
  // Divider sees magnitudes; signs are restored when the result is written out.
  assign a_x     = {{WIDTH{a_q[WIDTH-1]}}, a_q};
  assign b_x     = {{WIDTH{b_q[WIDTH-1]}}, b_q};
  assign dvd_mag = a_q[WIDTH-1] ? -a_q : a_q;
  assign dsr_mag = b_q[WIDTH-1] ? -b_q : b_q;
  assign quo_fix = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -quo_ext : quo_ext;
  assign rem_fix = a_q[WIDTH-1] ? -rem_ext : rem_ext;
`else
  assign a_x     = {{WIDTH{1'b0}}, a_q};
  assign b_x     = {{WIDTH{1'b0}}, b_q};
  assign dvd_mag = a_q;
  assign dsr_mag = b_q;
  assign quo_fix = quo_ext;
  assign rem_fix = rem_ext;
`endif

  seq_divider #(.WIDTH(WIDTH)) u_div (
    .clk      (clock_i),
    .rst_n    (reset_i),
    .init     (div_init),
    .dividend (dvd_mag),
    .divisor  (dsr_mag),
    .quotient (div_quo),
    .remainder(div_rem),
    .last     (div_last)
  );

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i) state_nxt = EXEC;
      EXEC:    state_nxt = div_init ? DIV : DONE;
      DIV:     if (div_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy_o = (state != IDLE);

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      a_q    <= '0;
      b_q    <= '0;
      fct_q  <= '0;
      alu_q  <= '0;
      div0_q <= 1'b0;
      res_o  <= '0;
      rem_o  <= '0;
      div0_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      done_o <= (state == DONE);
      if (state == IDLE && start_i) begin
        a_q   <= a_i;
        b_q   <= b_i;
        fct_q <= fct_i;
      end
      if (state == EXEC) begin
        div0_q <= (fct_q == FCT_DIV) && (b_q == '0);
        case (fct_q)
          FCT_ADD: alu_q <= a_x + b_x;
          FCT_SUB: alu_q <= a_x - b_x;
          FCT_MUL: alu_q <= a_x * b_x;
          default: alu_q <= '0;
        endcase
      end
      if (state == DONE) begin
        res_o  <= (fct_q == FCT_DIV && !div0_q) ? quo_fix : alu_q;
        rem_o  <= (fct_q == FCT_DIV && !div0_q) ? rem_fix : '0;
        div0_o <= div0_q;
      end
    end
  end

endmodule

// File: tb/tb_seq_calculator.sv
// Directed and random checks of seq_calculator against an integer-arithmetic reference model.
module tb_seq_calculator;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic [1:0]     f = '0;
  logic           busy, done, div0;
  logic [2*W-1:0] res, rem;
  int             checks = 0;
  int             errors = 0;

  always #5 clk = ~clk;

  seq_calculator #(.WIDTH(W)) dut (
    .clock_i(clk),
    .reset_i(rst_n),
    .start_i(start),
    .a_i    (a),
    .b_i    (b),
    .fct_i  (f),
    .busy_o (busy),
    .res_o  (res),
    .rem_o  (rem),
    .done_o (done),
    .div0_o (div0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, truncating division, results taken mod 2^(2W).
  function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic [1:0] mf,
                                output logic [2*W-1:0] r, output logic [2*W-1:0] rm, output logic z);
    int sa, sb;
`ifdef CALC_SIGNED_EN
    sa = $signed(ma);
    sb = $signed(mb);
`else
    sa = int'(ma);
    sb = int'(mb);
`endif
    r = '0; rm = '0; z = 1'b0;
    case (mf)
      2'b00: r = (2*W)'(sa + sb);
      2'b01: r = (2*W)'(sa - sb);
      2'b10: r = (2*W)'(sa * sb);
      default: begin
        if (sb == 0) z = 1'b1;
        else begin
          r  = (2*W)'(sa / sb);
          rm = (2*W)'(sa % sb);
        end
      end
    endcase
  endfunction

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic [1:0] tf, input string tag);
    logic [2*W-1:0] er, erm;
    logic           ez;
    int             lat, busy_cnt, exp_lat;
    model(ta, tb_v, tf, er, erm, ez);
    exp_lat = (tf == 2'b11 && tb_v != '0) ? W + 2 : 2;
    @(negedge clk);
    a = ta; b = tb_v; f = tf; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); f = 2'($urandom);
    lat = 0; busy_cnt = 0;
    while (!done && lat < 100) begin
      if (busy) busy_cnt++;
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(exp_lat));
    check({tag, " busy_at_done"}, 32'(busy), 32'd0);
    check({tag, " res"}, 32'(res), 32'(er));
    check({tag, " rem"}, 32'(rem), 32'(erm));
    check({tag, " div0"}, 32'(div0), 32'(ez));
    @(posedge clk);
    #1;
    check({tag, " done_pulse"}, 32'(done), 32'd0);
    check({tag, " res_held"}, 32'(res), 32'(er));
  endtask

  initial begin
    logic [W-1:0]   ra, rb, a2, b2;
    logic [1:0]     rf;
    logic [2*W-1:0] er, erm;
    logic           ez;
    int             n, dones;

    a = W'($urandom); b = W'($urandom); start = 1'b1;
    #12;
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst res", 32'(res), 32'd0);
    check("rst rem", 32'(rem), 32'd0);
    check("rst div0", 32'(div0), 32'd0);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    run_op(8'h03, 8'h07, 2'b10, "mul3x7");
    check("mul3x7 literal", 32'(res), 32'h0015);
    run_op(8'h03, 8'h07, 2'b01, "sub3-7");
    check("sub3-7 literal", 32'(res), 32'hFFFC);
    run_op(8'd200, 8'd7, 2'b11, "div200/7");
    run_op(8'hF9, 8'd2, 2'b11, "div-7/2");
    run_op(8'd5, 8'd0, 2'b11, "div5/0");
    check("div5/0 flag", 32'(div0), 32'd1);
    run_op(8'd1, 8'd1, 2'b00, "add1+1");
    check("add after div0", 32'(div0), 32'd0);

    // Reset in the middle of a divide.
    @(negedge clk);
    a = 8'd100; b = 8'd3; f = 2'b11; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort res", 32'(res), 32'd0);
    check("abort rem", 32'(rem), 32'd0);
    check("abort done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    check("abort no_done", 32'(dones), 32'd0);
    run_op(8'd9, 8'd3, 2'b11, "div9/3");
    check("div9/3 literal", 32'(res), 32'd3);

    // start held high: each op uses its captured operands, one IDLE edge between ops.
    ra = W'($urandom); rb = W'($urandom); a2 = W'($urandom); b2 = W'($urandom);
    @(negedge clk);
    a = ra; b = rb; f = 2'b10; start = 1'b1;
    @(posedge clk);
    #1;
    a = a2; b = b2; f = 2'b01;
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    model(ra, rb, 2'b10, er, erm, ez);
    check("b2b op1 res", 32'(res), 32'(er));
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) begin
        a = W'($urandom); b = W'($urandom); f = 2'($urandom);
      end
    end while (!done && n < 100);
    start = 1'b0;
    model(a2, b2, 2'b01, er, erm, ez);
    check("b2b gap", 32'(n), 32'd3);
    check("b2b op2 res", 32'(res), 32'(er));
    @(posedge clk);
    #1;

    for (int i = 0; i < 25; i++) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      rf = 2'($urandom);
      run_op(ra, rb, rf, "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
